// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and opcode-class helpers for the multicycle ALU.
package alu_pkg;

  localparam logic [4:0] OpNop   = 5'h00;
  localparam logic [4:0] OpAdd   = 5'h01;
  localparam logic [4:0] OpSub   = 5'h02;
  localparam logic [4:0] OpAnd   = 5'h03;
  localparam logic [4:0] OpOr    = 5'h04;
  localparam logic [4:0] OpXor   = 5'h05;
  localparam logic [4:0] OpNor   = 5'h06;
  localparam logic [4:0] OpSll   = 5'h07;
  localparam logic [4:0] OpSrl   = 5'h08;
  localparam logic [4:0] OpSra   = 5'h09;
  localparam logic [4:0] OpSlt   = 5'h0A;
  localparam logic [4:0] OpSltu  = 5'h0B;
  localparam logic [4:0] OpMult  = 5'h0C;
  localparam logic [4:0] OpMultu = 5'h0D;
  localparam logic [4:0] OpDiv   = 5'h0E;
  localparam logic [4:0] OpDivu  = 5'h0F;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// Signed operands are processed as magnitudes; signs are re-applied to the final result.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mul,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               busy_q, mul_q, neg_q, neg_rem_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   acc_q, lo_q, opnd_q;
  logic [WIDTH-1:0]   acc_d, lo_d, a_mag, b_mag, diff;
  logic [WIDTH:0]     sum, shifted;
  logic [2*WIDTH-1:0] prod;
  logic               ge;

  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // done marks the final iteration; results are taken from next-state values on that edge
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd_q};
    diff    = shifted[WIDTH-1:0] - opnd_q;
    if (mul_q) begin
      acc_d = sum[WIDTH:1];
      lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      acc_d = ge ? diff : shifted[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], ge};
    end
    prod = neg_q ? -{acc_d, lo_d} : {acc_d, lo_d};
    if (mul_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_lo = neg_q ? -lo_d : lo_d;
      res_hi = neg_rem_q ? -acc_d : acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      mul_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
    end else if (start) begin
      busy_q    <= 1'b1;
      mul_q     <= is_mul;
      neg_q     <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_q <= is_signed && a[WIDTH-1];
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= a_mag;
      opnd_q    <= b_mag;
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ops complete in one cycle, mul/div iterate for WIDTH cycles.
// Results and flags are registered and held in DONE until the consumer accepts them.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             zero,
  output logic             gtz,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q;
  logic [WIDTH-1:0] alu_out_q, alu_hi_q;
  logic             zero_q, gtz_q, ovf_q, dbz_q, illegal_q, pend_ovf_q;

  logic [WIDTH-1:0] sum, diff, sc_out, sc_hi, md_lo, md_hi;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, sc_dbz, sc_illegal, md_start, md_done;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign alu_out   = alu_out_q;
  assign alu_hi    = alu_hi_q;
  assign zero      = zero_q;
  assign gtz       = gtz_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign illegal   = illegal_q;

  assign sum   = alu_a + alu_b;
  assign diff  = alu_a - alu_b;
  assign shamt = alu_b[SHW-1:0];

  // A zero divisor never enters the iterative unit; it resolves through the single-cycle path.
  assign md_start = in_valid && in_ready && is_muldiv(alu_op) && !(is_div(alu_op) && alu_b == '0);

  always_comb begin
    sc_out     = '0;
    sc_hi      = '0;
    sc_ovf     = 1'b0;
    sc_dbz     = 1'b0;
    sc_illegal = 1'b0;
    case (alu_op)
      OpNop, OpMult, OpMultu: sc_out = '0;
      OpAdd: begin
        sc_out = sum;
        sc_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OpSub: begin
        sc_out = diff;
        sc_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OpAnd:  sc_out = alu_a & alu_b;
      OpOr:   sc_out = alu_a | alu_b;
      OpXor:  sc_out = alu_a ^ alu_b;
      OpNor:  sc_out = ~(alu_a | alu_b);
      OpSll:  sc_out = alu_a << shamt;
      OpSrl:  sc_out = alu_a >> shamt;
      OpSra:  sc_out = $unsigned($signed(alu_a) >>> shamt);
      OpSlt:  sc_out = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      OpSltu: sc_out = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      OpDiv, OpDivu: begin
        sc_out = '1;
        sc_hi  = alu_a;
        sc_dbz = 1'b1;
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .is_mul   (alu_op == OpMult || alu_op == OpMultu),
    .is_signed(alu_op == OpMult || alu_op == OpDiv),
    .a        (alu_a),
    .b        (alu_b),
    .done     (md_done),
    .res_lo   (md_lo),
    .res_hi   (md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_out_q  <= '0;
      alu_hi_q   <= '0;
      zero_q     <= 1'b0;
      gtz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      illegal_q  <= 1'b0;
      pend_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            gtz_q      <= !alu_a[WIDTH-1] && (alu_a != '0);
            pend_ovf_q <= (alu_op == OpDiv) && (alu_a == MinNeg) && (alu_b == '1);
            if (md_start) begin
              state_q <= StBusy;
            end else begin
              state_q   <= StDone;
              alu_out_q <= sc_out;
              alu_hi_q  <= sc_hi;
              zero_q    <= (sc_out == '0);
              ovf_q     <= sc_ovf;
              dbz_q     <= sc_dbz;
              illegal_q <= sc_illegal;
            end
          end
        end
        StBusy: begin
          if (md_done) begin
            state_q   <= StDone;
            alu_out_q <= md_lo;
            alu_hi_q  <= md_hi;
            zero_q    <= (md_lo == '0);
            ovf_q     <= pend_ovf_q;
            dbz_q     <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32: latency, results, flags, handshake and reset.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_op = '0;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic        in_ready, out_valid, zero, gtz, ovf, dbz, illegal;
  logic [31:0] alu_out, alu_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  fl;  // {zero, gtz, ovf, dbz, illegal}
    int          lat;
  } vec_t;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .alu_hi   (alu_hi),
    .zero     (zero),
    .gtz      (gtz),
    .ovf      (ovf),
    .dbz      (dbz),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Leaves time 1 unit after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts the accept cycle as cycle 0; gives up after 100 cycles.
  task automatic wait_result(output int lat, output bit rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset handshake: got %b want 10", {in_ready, out_valid});
    end
    checks++;
    if ({alu_out, alu_hi} !== 64'h0) begin
      errors++; $display("FAIL reset result: got %h_%h want 0", alu_hi, alu_out);
    end
    checks++;
    if ({zero, gtz, ovf, dbz, illegal} !== 5'b0) begin
      errors++; $display("FAIL reset flags: got %b want 00000", {zero, gtz, ovf, dbz, illegal});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    int lat;
    bit rdy;
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_result(lat, rdy);
      checks++;
      if (lat != tbl[i].lat || rdy) begin
        errors++;
        $display("FAIL %s[%0d] latency: got %0d (ready_seen %0b) want %0d (ready_seen 0)",
                 name, i, lat, rdy, tbl[i].lat);
      end
      checks++;
      if (alu_out !== tbl[i].lo || alu_hi !== tbl[i].hi) begin
        errors++;
        $display("FAIL %s[%0d] result: got hi %h lo %h want hi %h lo %h",
                 name, i, alu_hi, alu_out, tbl[i].hi, tbl[i].lo);
      end
      checks++;
      if ({zero, gtz, ovf, dbz, illegal} !== tbl[i].fl) begin
        errors++;
        $display("FAIL %s[%0d] flags: got %b want %b", name, i,
                 {zero, gtz, ovf, dbz, illegal}, tbl[i].fl);
      end
      consume();
    end
  endtask

  task automatic test_single_cycle();
    vec_t t[$];
    t.push_back('{OpAdd,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b01100, 1});
    t.push_back('{OpSub,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 5'b11000, 1});
    t.push_back('{OpSub,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 5'b00100, 1});
    t.push_back('{OpAdd,  32'h80000000, 32'h80000000, 32'h00000000, 32'h0, 5'b10100, 1});
    t.push_back('{OpAnd,  32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 32'h0, 5'b00000, 1});
    t.push_back('{OpOr,   32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 32'h0, 5'b00000, 1});
    t.push_back('{OpXor,  32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 32'h0, 5'b00000, 1});
    t.push_back('{OpNor,  32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 32'h0, 5'b00000, 1});
    t.push_back('{OpSll,  32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 5'b01000, 1});
    t.push_back('{OpSrl,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 5'b00000, 1});
    t.push_back('{OpSra,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 5'b00000, 1});
    t.push_back('{OpSlt,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 5'b00000, 1});
    t.push_back('{OpSltu, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 5'b10000, 1});
    t.push_back('{OpNop,  32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 5'b11000, 1});
    t.push_back('{5'h15,  32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 5'b11001, 1});
    t.push_back('{5'h1F,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 5'b10001, 1});
    run_table("single", t);
  endtask

  task automatic test_muldiv();
    vec_t t[$];
    t.push_back('{OpMult,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 5'b00000, 33});
    t.push_back('{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b00000, 33});
    t.push_back('{OpMult,  32'h00000007, 32'h00000000, 32'h00000000, 32'h00000000, 5'b11000, 33});
    t.push_back('{OpDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b00000, 33});
    t.push_back('{OpDiv,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 5'b01000, 33});
    t.push_back('{OpDivu,  32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 5'b01000, 33});
    t.push_back('{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 5'b00100, 33});
    t.push_back('{OpDivu,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 5'b01010, 1});
    t.push_back('{OpDiv,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 5'b00010, 1});
    run_table("muldiv", t);
  endtask

  task automatic test_hold();
    int lat;
    bit rdy;
    issue(OpAdd, 32'd2, 32'd3);
    wait_result(lat, rdy);
    // A competing request is presented throughout DONE and the release cycle.
    @(negedge clk);
    alu_op = OpXor; alu_a = 32'hA; alu_b = 32'h6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || alu_out !== 32'd5 || alu_hi !== 32'd0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid %b ready %b out %h hi %h want 1 0 5 0",
                 i, out_valid, in_ready, alu_out, alu_hi);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL release: got valid %b ready %b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'hC) begin
      errors++; $display("FAIL accept_after_release: got valid %b out %h want 1 c", out_valid, alu_out);
    end
    consume();
  endtask

  task automatic test_ignore_busy();
    int lat;
    bit rdy;
    issue(OpMultu, 32'd6, 32'd7);
    @(negedge clk);
    alu_op = OpAdd; alu_a = 32'd1; alu_b = 32'd1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, rdy);
    checks++;
    if (lat + 5 != 33 || rdy || alu_out !== 32'd42 || alu_hi !== 32'd0) begin
      errors++;
      $display("FAIL ignore_busy: got lat %0d ready_seen %0b out %h hi %h want 33 0 2a 0",
               lat + 5, rdy, alu_out, alu_hi);
    end
    consume();
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL no_queue: got valid %b ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    bit rdy;
    issue(OpDivu, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || {alu_out, alu_hi} !== 64'h0 ||
        {zero, gtz, ovf, dbz, illegal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_busy: got ready %b valid %b out %h hi %h flags %b want 1 0 0 0 00000",
               in_ready, out_valid, alu_out, alu_hi, {zero, gtz, ovf, dbz, illegal});
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_busy_stale: got ready %b valid %b want 1 0", in_ready, out_valid);
    end
    issue(OpAdd, 32'd2, 32'd3);
    wait_result(lat, rdy);
    checks++;
    if (lat != 1 || alu_out !== 32'd5 || {zero, gtz, ovf, dbz, illegal} !== 5'b01000) begin
      errors++;
      $display("FAIL post_reset_add: got lat %0d out %h flags %b want 1 5 01000",
               lat, alu_out, {zero, gtz, ovf, dbz, illegal});
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_hold();
    test_ignore_busy();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
